// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter in front of the word RAM.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Requests carry the address at its widest supported size; the arbiter
  // zero-extends its ADR_W-bit port into it and slices it back out.
  localparam int ADR_MAX = 32;

  typedef struct packed {
    logic               cyc;
    logic               stb;
    logic               we;
    logic [3:0]         be;
    logic [ADR_MAX-1:0] adr;
    logic [31:0]        dat;
  } wb_req_t;

  // A master is asking for the bus only while both cyc and stb are high.
  function automatic logic is_req(wb_req_t r);
    return r.cyc & r.stb;
  endfunction

endpackage

// File: rtl/wb_arb2.sv
// Round-robin arbiter: CPU instruction bus (m0) and data bus (m1) share one
// RAM port. The grant is held until the slave acks, the master drops cyc or
// the optional timeout fires, and is always followed by one idle GAP cycle so
// a stretched or late ack can never complete a second request.
module wb_arb2
  import wb_arb_pkg::*;
#(
  parameter int ADR_W   = 7,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_be_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [31:0]      m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_be_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [31:0]      m1_dat_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [3:0]       s_be_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [31:0]      s_dat_o,
  input  logic             s_ack_i,
  input  logic [31:0]      s_dat_i
);

  // Counter value seen in the last grant cycle before the error fires.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             last_q, last_d;   // 1: master 1 was granted most recently
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wb_req_t          m0, m1, sel;
  logic             own1, ack, err;
  logic             unused_adr_hi;

  // Pack both master requests into the shared request type.
  always_comb begin
    m0 = '0;
    m0.cyc = m0_cyc_i;
    m0.stb = m0_stb_i;
    m0.we  = m0_we_i;
    m0.be  = m0_be_i;
    m0.adr[ADR_W-1:0] = m0_adr_i;
    m0.dat = m0_dat_i;
    m1 = '0;
    m1.cyc = m1_cyc_i;
    m1.stb = m1_stb_i;
    m1.we  = m1_we_i;
    m1.be  = m1_be_i;
    m1.adr[ADR_W-1:0] = m1_adr_i;
    m1.dat = m1_dat_i;
  end

  // Next-state, grant selection, ack/err routing and timeout counting.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = '0;
    sel     = '0;
    own1    = 1'b0;
    ack     = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the master that was not served last wins.
        if (is_req(m0) && (!is_req(m1) || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (is_req(m1)) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0, GNT1: begin
        own1  = (state_q == GNT1);
        sel   = own1 ? m1 : m0;
        cnt_d = cnt_q + 1'b1;
        // Ack takes priority over an abandoned cycle and over the timeout.
        if (s_ack_i) begin
          ack     = 1'b1;
          state_d = GAP;
        end else if (!sel.cyc) begin
          state_d = GAP;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          err     = 1'b1;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin memory and timeout counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset drops the grant in the same cycle, so no completion escapes.
  assign s_cyc_o  = rst_in & sel.cyc;
  assign s_stb_o  = rst_in & sel.cyc & sel.stb;
  assign s_we_o   = sel.we;
  assign s_be_o   = sel.be;
  assign s_adr_o  = sel.adr[ADR_W-1:0];
  assign s_dat_o  = sel.dat;
  assign m0_ack_o = rst_in & ack & ~own1;
  assign m1_ack_o = rst_in & ack & own1;
  assign m0_err_o = rst_in & err & ~own1;
  assign m1_err_o = rst_in & err & own1;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Address bits above ADR_W are zero by construction.
  assign unused_adr_hi = |(sel.adr >> ADR_W);

endmodule

// File: tb/tb_wb_arb2.sv
// Bench for wb_arb2 with a one-wait-state RAM slave model attached.
module tb_wb_arb2;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_be_i;
  logic [6:0]  m0_adr_i;
  logic [31:0] m0_dat_i;
  logic        m0_ack_o, m0_err_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_be_i;
  logic [6:0]  m1_adr_i;
  logic [31:0] m1_dat_i;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_be_o;
  logic [6:0]  s_adr_o;
  logic [31:0] s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  // slave_mode: 0 normal RAM, 1 never acks, 2 repeats its ack in the next cycle
  int          slave_mode = 0;
  bit          ram_clear  = 1'b0;
  logic        ram_ack, extra_ack;
  logic [31:0] ram     [128];
  logic [31:0] exp_mem [128];

  logic        smp_ack0, smp_ack1, smp_err0, smp_err1, smp_scyc, smp_sstb, smp_swe, smp_sack;
  logic [3:0]  smp_sbe;
  logic [6:0]  smp_sadr;
  logic [31:0] smp_sdat, smp_dat0, smp_dat1;

  wb_arb2 #(.ADR_W(7), .TIMEOUT(8), .CNT_W(8)) dut (
    .clk_i(clk), .rst_in(rst_in),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    logic [31:0] v;
    v = i;
    return 32'h1357_0000 ^ (v * 32'h0101_0011);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // RAM slave: acks one edge after a strobe, read data registered with the ack.
  always @(posedge clk) begin
    if (ram_clear) for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
    if (!rst_in) begin
      ram_ack   <= 1'b0;
      extra_ack <= 1'b0;
    end else begin
      extra_ack <= (slave_mode == 2) && ram_ack;
      if (s_cyc_o && s_stb_o && !ram_ack && slave_mode != 1) begin
        ram_ack <= 1'b1;
        s_dat_i <= ram[s_adr_o];
        if (s_we_o) ram[s_adr_o] <= merge(ram[s_adr_o], s_dat_o, s_be_o);
      end else begin
        ram_ack <= 1'b0;
      end
    end
  end
  assign s_ack_i = ram_ack | extra_ack;

  task automatic req(input int m, input logic we, input logic [6:0] adr,
                     input logic [31:0] dat, input logic [3:0] be);
    if (m == 0) begin
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_be_i = be;
    end else begin
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_be_i = be;
    end
  endtask

  // One bus cycle: sample mid-cycle, then let masters that saw ack/err finish.
  task automatic step();
    @(negedge clk);
    smp_ack0 = m0_ack_o; smp_ack1 = m1_ack_o; smp_err0 = m0_err_o; smp_err1 = m1_err_o;
    smp_dat0 = m0_dat_o; smp_dat1 = m1_dat_o; smp_scyc = s_cyc_o; smp_sstb = s_stb_o;
    smp_swe = s_we_o; smp_sbe = s_be_o; smp_sadr = s_adr_o; smp_sdat = s_dat_o; smp_sack = s_ack_i;
    @(posedge clk);
    #1;
    cyc_n++;
    if (m0_cyc_i && (smp_ack0 || smp_err0)) begin
      if (smp_ack0 && m0_we_i) exp_mem[m0_adr_i] = merge(exp_mem[m0_adr_i], m0_dat_i, m0_be_i);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    end
    if (m1_cyc_i && (smp_ack1 || smp_err1)) begin
      if (smp_ack1 && m1_we_i) exp_mem[m1_adr_i] = merge(exp_mem[m1_adr_i], m1_dat_i, m1_be_i);
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; ram_clear = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_be_i = 0; m0_adr_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_be_i = 0; m1_adr_i = 0; m1_dat_i = 0;
    step();
    ram_clear = 1'b0;
    for (int i = 0; i < 128; i++) exp_mem[i] = init_val(i);
    req(0, 1'b1, 7'd3, 32'h1111_2222, 4'hF);
    step();
    checks++;
    if ({smp_ack0, smp_ack1, smp_err0, smp_err1, smp_scyc, smp_sstb} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold: ack/err/cyc/stb=%b required 000000",
               {smp_ack0, smp_ack1, smp_err0, smp_err1, smp_scyc, smp_sstb});
    end
    m0_cyc_i = 0; m0_stb_i = 0;
    rst_in = 1'b1;
    step();
    checks++;
    if ({smp_ack0, smp_ack1, smp_scyc, smp_sstb, smp_swe, smp_sbe, smp_sadr, smp_sdat} !== '0) begin
      errors++;
      $display("FAIL reset_idle_outputs: cyc=%b stb=%b we=%b be=%h adr=%h dat=%h required all 0",
               smp_scyc, smp_sstb, smp_swe, smp_sbe, smp_sadr, smp_sdat);
    end
  endtask

  task automatic test_single_read();
    int ack_c = -1, n_ack = 0;
    req(1, 1'b0, 7'd5, 32'h0, 4'hF);
    for (int c = 0; c < 8; c++) begin
      step();
      if (smp_ack1) begin n_ack++; if (ack_c < 0) ack_c = c; end
      if (c == 1) begin
        checks++;
        if ({smp_sstb, smp_swe, smp_sadr} !== {1'b1, 1'b0, 7'd5}) begin
          errors++;
          $display("FAIL read_fwd: stb/we/adr=%b/%b/%0d required 1/0/5", smp_sstb, smp_swe, smp_sadr);
        end
      end
      if (c == 2) begin
        checks++;
        if (smp_dat1 !== exp_mem[5] || smp_ack0 !== 1'b0) begin
          errors++;
          $display("FAIL read_data: m1_dat=%h m0_ack=%b required %h 0", smp_dat1, smp_ack0, exp_mem[5]);
        end
      end
      if (c == 3) begin
        checks++;
        if ({smp_sstb, smp_scyc, smp_ack1} !== 3'b0) begin
          errors++;
          $display("FAIL read_gap: stb/cyc/ack=%b required 000", {smp_sstb, smp_scyc, smp_ack1});
        end
      end
    end
    checks++;
    if (ack_c != 2 || n_ack != 1) begin
      errors++;
      $display("FAIL read_latency: ack cycle %0d count %0d required 2 and 1", ack_c, n_ack);
    end
  endtask

  task automatic test_simultaneous();
    int a0[$], a1[$];
    logic [31:0] d0 = 0, d1 = 0;
    rst_in = 1'b0; step(); rst_in = 1'b1;
    req(0, 1'b0, 7'd10, 32'h0, 4'hF);
    req(1, 1'b0, 7'd11, 32'h0, 4'hF);
    for (int c = 0; c < 14; c++) begin
      step();
      if (smp_ack0) begin a0.push_back(c); if (c == 2) d0 = smp_dat0; end
      if (smp_ack1) begin a1.push_back(c); d1 = smp_dat1; end
      if (c == 2) req(0, 1'b0, 7'd12, 32'h0, 4'hF);
    end
    // m0 wins the first tie, m1 wins the second, m0 then follows.
    checks++;
    if (a0.size() != 2 || a0[0] != 2 || a0[1] != 10) begin
      errors++;
      $display("FAIL tie_m0_acks: count %0d first %0d required 2 acks at 2,10",
               a0.size(), (a0.size() > 0) ? a0[0] : -1);
    end
    checks++;
    if (a1.size() != 1 || a1[0] != 6) begin
      errors++;
      $display("FAIL tie_m1_acks: count %0d first %0d required 1 ack at 6",
               a1.size(), (a1.size() > 0) ? a1[0] : -1);
    end
    checks++;
    if (d0 !== exp_mem[10] || d1 !== exp_mem[11]) begin
      errors++;
      $display("FAIL tie_data: %h %h required %h %h", d0, d1, exp_mem[10], exp_mem[11]);
    end
  endtask

  task automatic test_back_to_back();
    int acks[$];
    int n_err = 0;
    req(0, 1'b1, 7'd16, 32'hDEAD_BEEF, 4'b0011);
    for (int c = 0; c < 18; c++) begin
      step();
      if (smp_err0 || smp_err1) n_err++;
      if (smp_sstb) begin
        checks++;
        if (smp_sbe !== 4'b0011 || smp_sdat !== 32'hDEAD_BEEF || smp_swe !== 1'b1) begin
          errors++;
          $display("FAIL b2b_fwd: be=%b dat=%h we=%b required 0011 deadbeef 1", smp_sbe, smp_sdat, smp_swe);
        end
      end
      if (smp_ack0) begin
        acks.push_back(c);
        if (acks.size() < 4) req(0, 1'b1, 7'(16 + acks.size()), 32'hDEAD_BEEF, 4'b0011);
      end
    end
    checks++;
    if (acks.size() != 4 || acks[0] != 2 || acks[1] != 6 || acks[2] != 10 || acks[3] != 14 || n_err != 0) begin
      errors++;
      $display("FAIL b2b_spacing: %0d acks, %0d errs required 4 acks at 2,6,10,14 and 0 errs",
               acks.size(), n_err);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ram[16+k] !== {init_val(16+k) >> 16, 16'hBEEF}) begin
        errors++;
        $display("FAIL b2b_ram%0d: %h required %h", k, ram[16+k], {init_val(16+k) >> 16, 16'hBEEF});
      end
    end
  endtask

  task automatic test_ack_in_gap();
    int n0 = 0, n1 = 0, ack_c = -1;
    slave_mode = 2;
    req(0, 1'b0, 7'd20, 32'h0, 4'hF);
    for (int c = 0; c < 6; c++) begin
      step();
      if (smp_ack0) n0++;
      if (c == 3) begin
        checks++;
        if ({smp_sack, smp_ack0, smp_ack1} !== 3'b100) begin
          errors++;
          $display("FAIL gap_ack_blocked: s_ack/m0_ack/m1_ack=%b required 100", {smp_sack, smp_ack0, smp_ack1});
        end
      end
    end
    checks++;
    if (n0 != 1) begin
      errors++;
      $display("FAIL gap_ack_count: m0 acks %0d required 1", n0);
    end
    slave_mode = 0;
    req(1, 1'b0, 7'd21, 32'h0, 4'hF);
    for (int c = 0; c < 6; c++) begin
      step();
      if (smp_ack1) begin
        n1++; ack_c = c;
        checks++;
        if (smp_dat1 !== exp_mem[21]) begin
          errors++;
          $display("FAIL gap_next_data: %h required %h", smp_dat1, exp_mem[21]);
        end
      end
    end
    checks++;
    if (n1 != 1 || ack_c != 2) begin
      errors++;
      $display("FAIL gap_next_xfer: acks %0d at %0d required 1 at 2", n1, ack_c);
    end
  endtask

  task automatic test_timeout();
    int errs[$];
    int n_ack = 0;
    slave_mode = 1;
    req(0, 1'b1, 7'd30, 32'hCAFE_F00D, 4'hF);
    for (int c = 0; c < 12; c++) begin
      step();
      if (smp_err0) errs.push_back(c);
      if (smp_ack0 || smp_ack1 || smp_err1) n_ack++;
      if (c == 9 || c == 10) begin
        checks++;
        if ({smp_scyc, smp_sstb} !== 2'b00) begin
          errors++;
          $display("FAIL timeout_release%0d: cyc/stb=%b required 00", c, {smp_scyc, smp_sstb});
        end
      end
    end
    slave_mode = 0;
    checks++;
    if (errs.size() != 1 || errs[0] != 8 || n_ack != 0) begin
      errors++;
      $display("FAIL timeout_err: %0d err pulses first at %0d, other completions %0d required 1 at 8, 0",
               errs.size(), (errs.size() > 0) ? errs[0] : -1, n_ack);
    end
  endtask

  task automatic test_reset_mid();
    int a0 = -1, a1 = -1;
    req(1, 1'b0, 7'd40, 32'h0, 4'hF);
    step();
    step();
    checks++;
    if (smp_scyc !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant: s_cyc=%b required 1", smp_scyc);
    end
    rst_in = 1'b0;
    step();
    checks++;
    if ({smp_ack1, smp_err1, smp_ack0} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_no_ack: m1 ack/err, m0 ack=%b required 000", {smp_ack1, smp_err1, smp_ack0});
    end
    rst_in = 1'b1;
    req(0, 1'b0, 7'd41, 32'h0, 4'hF);
    for (int c = 3; c < 12; c++) begin
      step();
      if (c == 3) begin
        checks++;
        if ({smp_scyc, smp_ack1} !== 2'b00) begin
          errors++;
          $display("FAIL rstmid_dropped: s_cyc/m1_ack=%b required 00", {smp_scyc, smp_ack1});
        end
      end
      if (smp_ack0 && a0 < 0) a0 = c;
      if (smp_ack1 && a1 < 0) a1 = c;
    end
    checks++;
    if (a0 != 5 || a1 != 9) begin
      errors++;
      $display("FAIL rstmid_tie: m0 ack at %0d m1 at %0d required 5 and 9", a0, a1);
    end
  endtask

  // Random traffic against transaction-level rules: ordered memory contents,
  // exclusive completions, 4-cycle spacing, round-robin and bounded wait.
  task automatic test_random();
    int start[2];
    int last_m = -1, last_c = -100;
    bit other_pend = 1'b0;
    bit pre[2], ak[2];
    logic prew[2];
    logic [6:0] pra[2];
    logic [31:0] dt[2];
    for (int c = 0; c < 700; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (c < 680 && !((m == 0) ? m0_cyc_i : m1_cyc_i) && $urandom_range(0, 2) == 0) begin
          req(m, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom, 4'($urandom_range(0, 15)));
          start[m] = c;
        end
      end
      pre[0] = m0_cyc_i; pre[1] = m1_cyc_i;
      prew[0] = m0_we_i; prew[1] = m1_we_i;
      pra[0] = m0_adr_i; pra[1] = m1_adr_i;
      step();
      ak[0] = smp_ack0; ak[1] = smp_ack1; dt[0] = smp_dat0; dt[1] = smp_dat1;
      if (smp_err0 || smp_err1) begin
        checks++; errors++;
        $display("FAIL rnd_err: unexpected err at cycle %0d", c);
      end
      if (ak[0] && ak[1]) begin
        checks++; errors++;
        $display("FAIL rnd_double_ack: both masters acked at cycle %0d", c);
      end
      for (int m = 0; m < 2; m++) begin
        if (ak[m]) begin
          checks++;
          if (!pre[m]) begin
            errors++;
            $display("FAIL rnd_ack_idle: m%0d acked without request at cycle %0d", m, c);
          end
          checks++;
          if (!prew[m] && dt[m] !== exp_mem[pra[m]]) begin
            errors++;
            $display("FAIL rnd_rdata: m%0d adr %0d got %h required %h", m, pra[m], dt[m], exp_mem[pra[m]]);
          end
          checks++;
          if (c - last_c < 4) begin
            errors++;
            $display("FAIL rnd_spacing: acks %0d cycles apart required >= 4", c - last_c);
          end
          checks++;
          if (last_m == m && other_pend) begin
            errors++;
            $display("FAIL rnd_round_robin: m%0d served twice while m%0d waited", m, 1 - m);
          end
          other_pend = pre[1-m];
          last_m = m;
          last_c = c;
        end else if (pre[m] && c - start[m] > 10) begin
          checks++; errors++;
          $display("FAIL rnd_starve: m%0d waited %0d cycles required <= 10", m, c - start[m]);
          if (m == 0) begin m0_cyc_i = 0; m0_stb_i = 0; end
          else begin m1_cyc_i = 0; m1_stb_i = 0; end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_ack_in_gap();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
